// File: rtl/adder_share_sequencer.sv
// adder_share_sequencer
// Round-robin front end that time-shares one external combinational XLEN-bit
// adder between NREQ clients. Narrow ops take one adder pass, wide ops take
// two passes with the low-word carry chained into the high word. The result
// is held on the rsp_* port until the consumer takes it.
module adder_share_sequencer #(
    parameter int XLEN = 64,
    parameter int NREQ = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*2*XLEN-1:0] req_a,
    input  logic [NREQ*2*XLEN-1:0] req_b,
    input  logic [NREQ-1:0]        req_sub,
    input  logic [NREQ-1:0]        req_wide,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [2*XLEN-1:0]      rsp_result,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic [XLEN-1:0]        add_a,
    output logic [XLEN-1:0]        add_b,
    output logic                   add_c0,
    input  logic [XLEN-1:0]        add_result,
    input  logic                   add_cout
);

    typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

    state_t              state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      op_id;
    logic                op_wide;

    // Operand/result holding registers; only meaningful while an op is in flight.
    logic [2*XLEN-1:0]   op_a;
    logic [2*XLEN-1:0]   op_b;
    logic [XLEN-1:0]     res_lo;

    logic                grant_found;
    logic [IDW-1:0]      grant_id;
    logic                hi_hit;
    logic [IDW-1:0]      hi_id;
    logic [2*XLEN-1:0]   sel_a;
    logic [2*XLEN-1:0]   sel_b;
    logic                sel_sub;
    logic                accept;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Round-robin pick: lowest valid index at/after rr_ptr, else lowest overall (wrap).
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        hi_hit      = 1'b0;
        hi_id       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_hit = 1'b1;
                    hi_id  = IDW'(i);
                end
            end
        end
        if (hi_hit) begin
            grant_id = hi_id;
        end
    end

    // Granted requester's operands; B is pre-inverted for subtract so the adder only ever adds.
    always_comb begin
        sel_sub = req_sub[grant_id];
        sel_a   = req_a[int'(grant_id) * 2 * XLEN +: 2 * XLEN];
        sel_b   = req_b[int'(grant_id) * 2 * XLEN +: 2 * XLEN] ^ {2 * XLEN{sel_sub}};
    end

    assign accept = (state == IDLE) && grant_found;

    // One-hot accept strobe; forced low while reset is asserted so every output reads 0.
    always_comb begin
        req_ready = '0;
        if (rst_n && accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Operand capture at accept and low-word capture during the LO pass.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= sel_a;
            op_b <= sel_b;
        end
        if (state == LO) begin
            res_lo <= add_result;
        end
    end

    // Sequencer FSM with registered adder drive and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            op_wide    <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_c0     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_id   <= grant_id;
                        op_wide <= req_wide[grant_id];
                        add_a   <= sel_a[XLEN-1:0];
                        add_b   <= sel_b[XLEN-1:0];
                        add_c0  <= sel_sub;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (op_wide) begin
                        add_a  <= op_a[2*XLEN-1:XLEN];
                        add_b  <= op_b[2*XLEN-1:XLEN];
                        add_c0 <= add_cout;
                        state  <= HI;
                    end else begin
                        add_a      <= '0;
                        add_b      <= '0;
                        add_c0     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= op_id;
                        rsp_result <= {{XLEN{1'b0}}, add_result};
                        rsp_cout   <= add_cout;
                        rsp_ovf    <= signed_ovf(op_a[XLEN-1], op_b[XLEN-1], add_result[XLEN-1]);
                        state      <= RSP;
                    end
                end
                HI: begin
                    add_a      <= '0;
                    add_b      <= '0;
                    add_c0     <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_id     <= op_id;
                    rsp_result <= {add_result, res_lo};
                    rsp_cout   <= add_cout;
                    rsp_ovf    <= signed_ovf(op_a[2*XLEN-1], op_b[2*XLEN-1], add_result[XLEN-1]);
                    state      <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_id     <= '0;
                        rsp_result <= '0;
                        rsp_cout   <= 1'b0;
                        rsp_ovf    <= 1'b0;
                        rr_ptr     <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_sequencer.sv
// Bench for adder_share_sequencer: models the external adder, runs directed
// vectors with hand-computed results, and compares every cycle against an
// arithmetic reference model of arbitration, latency and results.
`timescale 1ns/1ps
module tb_adder_share_sequencer;
    localparam int XLEN = 64;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int W2   = 2 * XLEN;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W2-1:0]   req_a;
    logic [NREQ*W2-1:0]   req_b;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      req_wide;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W2-1:0]        rsp_result;
    logic                 rsp_cout;
    logic                 rsp_ovf;
    logic [XLEN-1:0]      add_a;
    logic [XLEN-1:0]      add_b;
    logic                 add_c0;
    logic [XLEN-1:0]      add_result;
    logic                 add_cout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External combinational adder
    assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_c0};

    adder_share_sequencer #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_wide(req_wide),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
        .add_result(add_result), .add_cout(add_cout)
    );

    task automatic chk(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [W2-1:0]  res;
        logic           cout;
        logic           ovf;
    } rsp_t;

    // Reference arithmetic: exact unsigned and signed results at the op width.
    function automatic rsp_t model_op(input int id, input logic [W2-1:0] a, input logic [W2-1:0] b,
                                      input logic sub, input logic wide);
        rsp_t r;
        logic [XLEN:0]        n_sum;
        logic signed [XLEN:0] n_s;
        logic [W2:0]          w_sum;
        logic signed [W2:0]   w_s;
        r.id = IDW'(id);
        if (!wide) begin
            n_sum = sub ? {1'b0, a[XLEN-1:0]} - {1'b0, b[XLEN-1:0]}
                        : {1'b0, a[XLEN-1:0]} + {1'b0, b[XLEN-1:0]};
            n_s   = sub ? $signed({a[XLEN-1], a[XLEN-1:0]}) - $signed({b[XLEN-1], b[XLEN-1:0]})
                        : $signed({a[XLEN-1], a[XLEN-1:0]}) + $signed({b[XLEN-1], b[XLEN-1:0]});
            r.res  = {{XLEN{1'b0}}, n_sum[XLEN-1:0]};
            r.cout = sub ? (a[XLEN-1:0] >= b[XLEN-1:0]) : n_sum[XLEN];
            r.ovf  = (n_s[XLEN] != n_s[XLEN-1]);
        end else begin
            w_sum = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
            w_s   = sub ? $signed({a[W2-1], a}) - $signed({b[W2-1], b})
                        : $signed({a[W2-1], a}) + $signed({b[W2-1], b});
            r.res  = w_sum[W2-1:0];
            r.cout = sub ? (a >= b) : w_sum[W2];
            r.ovf  = (w_s[W2] != w_s[W2-1]);
        end
        return r;
    endfunction

    // Reference model state and per-cycle comparison
    logic            m_busy = 1'b0;
    int              m_due  = 0;
    int              m_rr   = 0;
    rsp_t            m_exp;
    int              mon_g;
    logic [NREQ-1:0] mon_eg;
    logic            mon_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {rsp_valid, rsp_id, rsp_cout, rsp_ovf, add_c0, req_ready}, '0);
            chk("reset_result", rsp_result | {add_a, add_b}, '0);
            m_busy = 1'b0;
            m_rr   = 0;
        end else begin
            mon_g  = -1;
            mon_eg = '0;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (mon_g < 0 && req_valid[(m_rr + k) % NREQ]) mon_g = (m_rr + k) % NREQ;
                end
            end
            if (mon_g >= 0) mon_eg[mon_g] = 1'b1;
            chk("req_ready", req_ready, mon_eg);
            mon_v = m_busy && (cyc >= m_due);
            chk("rsp_valid", rsp_valid, mon_v);
            if (mon_v) begin
                chk("rsp_id", rsp_id, m_exp.id);
                chk("rsp_result", rsp_result, m_exp.res);
                chk("rsp_flags", {rsp_cout, rsp_ovf}, {m_exp.cout, m_exp.ovf});
            end
            if (!(m_busy && cyc < m_due)) begin
                chk("adder_idle", {add_c0, add_a | add_b}, '0);
            end
            if (mon_v && rsp_ready) begin
                m_busy = 1'b0;
                m_rr   = (int'(m_exp.id) + 1) % NREQ;
            end else if (mon_g >= 0) begin
                m_busy = 1'b1;
                m_due  = cyc + (req_wide[mon_g] ? 3 : 2);
                m_exp  = model_op(mon_g, req_a[mon_g*W2 +: W2], req_b[mon_g*W2 +: W2],
                                  req_sub[mon_g], req_wide[mon_g]);
            end
        end
    end

    task automatic do_req(input int i, input logic [W2-1:0] a, input logic [W2-1:0] b,
                          input logic sub, input logic wide, output int acc);
        req_a[i*W2 +: W2] = a;
        req_b[i*W2 +: W2] = b;
        req_sub[i]  = sub;
        req_wide[i] = wide;
        req_valid[i] = 1'b1;
        acc = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                acc = cyc;
                break;
            end
        end
        chk("accept_seen", W2'(acc >= 0), 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rc = cyc;
                break;
            end
        end
        chk("rsp_seen", W2'(rc >= 0), 1);
    endtask

    int          acc, rc, n;
    int          gid[4];
    int          gcyc[4];
    int          exp_g[4] = '{0, 1, 0, 1};
    logic [W2-1:0] snap;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        req_sub = '0; req_wide = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rsp_valid, req_ready, add_c0}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Narrow add, requester 0
        do_req(0, 5, 7, 1'b0, 1'b0, acc);
        wait_rsp(rc);
        chk("t1_latency", W2'(rc - acc), 2);
        chk("t1_result", rsp_result, 12);
        chk("t1_flags", {rsp_id, rsp_cout, rsp_ovf}, 0);
        @(posedge clk); #1;

        // Narrow subtracts, requester 1
        do_req(1, 3, 5, 1'b1, 1'b0, acc);
        wait_rsp(rc);
        chk("t2a_result", rsp_result, 128'hFFFF_FFFF_FFFF_FFFE);
        chk("t2a_id_cout", {rsp_id, rsp_cout}, 2'b10);
        @(posedge clk); #1;
        do_req(1, 5, 3, 1'b1, 1'b0, acc);
        wait_rsp(rc);
        chk("t2b_result", rsp_result, 2);
        chk("t2b_cout", rsp_cout, 1);
        @(posedge clk); #1;

        // Wide add with carry into the high word
        do_req(0, 128'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b1, acc);
        wait_rsp(rc);
        chk("t3_latency", W2'(rc - acc), 3);
        chk("t3_result", rsp_result, 128'h1_0000_0000_0000_0000);
        chk("t3_flags", {rsp_cout, rsp_ovf}, 0);
        @(posedge clk); #1;

        // Narrow signed overflow
        do_req(1, 128'h7FFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0, acc);
        wait_rsp(rc);
        chk("ovf_result", rsp_result, 128'h8000_0000_0000_0000);
        chk("ovf_flag", {rsp_cout, rsp_ovf}, 2'b01);
        @(posedge clk); #1;

        // Both requesters valid continuously: grants alternate
        req_a[0 +: W2] = 10; req_b[0 +: W2] = 1; req_sub[0] = 1'b0; req_wide[0] = 1'b0;
        req_a[W2 +: W2] = 20; req_b[W2 +: W2] = 2; req_sub[1] = 1'b1; req_wide[1] = 1'b0;
        req_valid = 2'b11;
        n = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                gid[n]  = req_ready[1] ? 1 : 0;
                gcyc[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("t4_grants", W2'(n), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n) chk("t4_grant_order", W2'(gid[k]), W2'(exp_g[k]));
            if (k > 0 && k < n) chk("t4_grant_spacing", W2'(gcyc[k] - gcyc[k-1]), 3);
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure held in RSP while requester 1 waits
        rsp_ready = 1'b0;
        do_req(0, 100, 23, 1'b0, 1'b0, acc);
        req_a[W2 +: W2] = 50; req_b[W2 +: W2] = 8; req_sub[1] = 1'b1; req_wide[1] = 1'b0;
        req_valid[1] = 1'b1;
        wait_rsp(rc);
        chk("t5_result", rsp_result, 123);
        snap = rsp_result;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t5_hold", {rsp_valid, req_ready, rsp_id, rsp_result}, {1'b1, 2'b00, 1'b0, snap});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_last_rsp", rsp_valid, 1);
        @(negedge clk);
        chk("t5_idle_grant", {rsp_valid, req_ready}, 3'b010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(rc);
        chk("t5_second", {rsp_id, rsp_result}, {1'b1, 128'd42});
        @(posedge clk); #1;

        // Asynchronous reset during the HI pass
        do_req(0, 1, 1, 1'b0, 1'b0, acc);
        wait_rsp(rc);
        chk("t6_pre", rsp_result, 2);
        @(posedge clk); #1;
        do_req(1, {64'h1234, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 1'b0, 1'b1, acc);
        @(posedge clk); #1;
        chk("t6_hi_drive", {add_c0, add_b, add_a}, {1'b1, 64'h0, 64'h1234});
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {rsp_valid, add_c0, add_a, req_ready}, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("t6_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("t6_rr_reset", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
